// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, receiver state encoding and clog2 helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous first-word fall-through FIFO with push/pop/full/empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with voting, error flags,
//            break detection and a FWFT receive FIFO on a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 Rs232_Rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 brk,
    output logic                 busy
);

    localparam int OS_W = clog2(OVERSAMPLE);
    localparam int BC_W = clog2(DATA_BITS) + 1;
    localparam int FW   = DATA_BITS + 2;

    localparam logic [OS_W-1:0] c_os_first = OS_W'(1);
    localparam logic [OS_W-1:0] c_os_lo    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] c_os_mid   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] c_os_hi    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] c_os_last  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] c_last_dat = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] c_last_stp = BC_W'(STOP_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 r_sync1, r_sync2, r_rx_d;
    logic [DIV_W-1:0]     r_div;
    logic [DIV_W-1:0]     r_tick_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic                 r_s0, r_s1;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_par_bit, r_ferr;
    logic                 r_brk_hold;
    logic                 r_brk, r_overrun;

    logic                 w_rx, w_fall, w_tick;
    logic                 w_s_lo, w_s_mid, w_s_hi;
    logic                 w_vote, w_par_exp;
    logic                 w_done, w_frame_ferr, w_is_brk;
    logic                 w_push, w_pop, w_full, w_empty;
    logic [FW-1:0]        w_head;

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_d & ~r_sync2;
    assign w_tick = (r_state != ST_IDLE) && (r_tick_cnt == r_div);

    // Tick numbers count ticks elapsed since the start edge
    assign w_s_lo  = w_tick && (r_os_cnt == c_os_lo);
    assign w_s_mid = w_tick && (r_os_cnt == c_os_mid);
    assign w_s_hi  = w_tick && (r_os_cnt == c_os_hi);
    assign w_vote  = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    assign w_par_exp    = (PARITY == PARITY_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_frame_ferr = (r_bit_cnt == '0) ? ~w_vote : r_ferr;
    assign w_is_brk     = w_done && (r_shift == '0) && w_frame_ferr &&
                          ((PARITY == PARITY_NONE) || !r_par_bit);
    assign w_push       = w_done && !w_is_brk;
    assign w_pop        = m_valid & m_ready;

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_brk_hold) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_s_hi) w_state_nxt = w_vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_s_hi && (r_bit_cnt == c_last_dat))
                    w_state_nxt = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (w_s_hi) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_s_hi && (r_bit_cnt == c_last_stp)) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_os_cnt   <= c_os_first;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk_hold <= 1'b0;
            r_brk      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1   <= Rs232_Rx;
            r_sync2   <= r_sync1;
            r_rx_d    <= r_sync2;
            r_brk     <= w_is_brk;
            r_overrun <= w_push & w_full & ~w_pop;

            if (r_state == ST_IDLE) begin
                r_tick_cnt <= '0;
                r_os_cnt   <= c_os_first;
                r_bit_cnt  <= '0;
                if (w_state_nxt == ST_START) begin
                    r_div     <= baud_div;
                    r_perr    <= 1'b0;
                    r_par_bit <= 1'b0;
                    r_ferr    <= 1'b0;
                end
            end else if (w_tick) begin
                r_tick_cnt <= '0;
                r_os_cnt   <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_s_lo)  r_s0 <= w_rx;
            if (w_s_mid) r_s1 <= w_rx;

            if (w_s_hi) begin
                r_bit_cnt <= (w_state_nxt != r_state) ? '0 : r_bit_cnt + 1'b1;
                case (r_state)
                    ST_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    ST_PARITY: begin
                        r_par_bit <= w_vote;
                        r_perr    <= (w_vote != w_par_exp);
                    end
                    ST_STOP:   if (r_bit_cnt == '0) r_ferr <= ~w_vote;
                    default:   ;
                endcase
            end

            // After a break the line must return high before a new start is accepted
            if (w_is_brk)                r_brk_hold <= 1'b1;
            else if (r_brk_hold && w_rx) r_brk_hold <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_push  (w_push),
        .i_data  ({r_perr, w_frame_ferr, r_shift}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid = ~w_empty;
    assign m_data  = w_head[DATA_BITS-1:0] & {DATA_BITS{m_valid}};
    assign m_ferr  = w_head[DATA_BITS]     & m_valid;
    assign m_perr  = w_head[DATA_BITS+1]   & m_valid;
    assign overrun = r_overrun;
    assign brk     = r_brk;
    assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire
